// File: rtl/dispatch_queue_if.sv
// ------------------------------------------------------------------------
// dispatch_queue_if: rename-side enqueue group and RS write-port group. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

interface dispatch_queue_if #(
  parameter int ENQ_WIDTH = 2,
  parameter int BANK_NUM  = 2,
  parameter int RS_W      = 27,
  parameter int OPT_W     = 8
);
  logic [ENQ_WIDTH-1:0][RS_W-1:0]  rs_base_i;
  logic [ENQ_WIDTH-1:0][OPT_W-1:0] option_code_i;
  logic [ENQ_WIDTH-1:0]            enq_valid_i;
  logic                            enq_ready_o;
  logic [BANK_NUM-1:0][RS_W-1:0]   rs_base_o;
  logic [BANK_NUM-1:0][OPT_W-1:0]  option_code_o;
  logic [BANK_NUM-1:0]             wr_valid_o;
  logic [BANK_NUM-1:0]             wr_ready_i;

  // master: the queue itself (producer toward the RS banks)
  modport master (
    input  rs_base_i, option_code_i, enq_valid_i, wr_ready_i,
    output enq_ready_o, rs_base_o, option_code_o, wr_valid_o
  );

  // slave: rename stage plus RS banks
  modport slave (
    output rs_base_i, option_code_i, enq_valid_i, wr_ready_i,
    input  enq_ready_o, rs_base_o, option_code_o, wr_valid_o
  );
endinterface

`default_nettype wire

// File: rtl/dispatch_queue.sv
// ------------------------------------------------------------------------
// dispatch_queue: in-order rename-to-RS buffer with writeback wakeup/bypass. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

`ifndef WB_WIDTH
`define WB_WIDTH 2
`endif
`ifndef PHY_REG_NUM
`define PHY_REG_NUM 64
`endif

module dispatch_queue #(
  parameter int QUEUE_DEPTH = 8,
  parameter int ENQ_WIDTH   = 2,
  parameter int BANK_NUM    = 2,
  parameter int OPT_W       = 8
) (
  input  wire                                                clk,
  input  wire                                                a_rst_n,
  input  wire                                                flush_i,
  input  wire [`WB_WIDTH-1:0]                                wb_i,
  input  wire [`WB_WIDTH-1:0][$clog2(`PHY_REG_NUM)-1:0]      wb_pdest_i,
  dispatch_queue_if.master                                   dq
);

  localparam int WB_W   = `WB_WIDTH;
  localparam int PREG_W = $clog2(`PHY_REG_NUM);
  localparam int ROB_W  = 6;
  localparam int IDX_W  = $clog2(QUEUE_DEPTH);
  localparam int PTR_W  = IDX_W + 1;
  localparam logic [PTR_W-1:0] ENQ_LIMIT = PTR_W'(QUEUE_DEPTH - ENQ_WIDTH);

  typedef struct packed {
    logic              valid;
    logic [ROB_W-1:0]  rob_idx;
    logic [PREG_W-1:0] pdest;
    logic [PREG_W-1:0] psrc0;
    logic              psrc0_ready;
    logic [PREG_W-1:0] psrc1;
    logic              psrc1_ready;
  } rs_base_t;

  localparam int RS_W = $bits(rs_base_t);

  rs_base_t                       mem     [QUEUE_DEPTH];
  logic [OPT_W-1:0]               opt_mem [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0]         live;
  logic [PTR_W-1:0]               head;
  logic [PTR_W-1:0]               tail;
  logic [PTR_W-1:0]               count;
  logic [PTR_W-1:0]               enq_n;
  logic [PTR_W-1:0]               deq_k;
  logic                           enq_ready;
  logic [BANK_NUM-1:0]            wr_valid;
  logic [IDX_W-1:0]               rd_idx  [BANK_NUM];
  logic [IDX_W-1:0]               wr_idx  [ENQ_WIDTH];
  rs_base_t                       bypass  [BANK_NUM];
  logic [BANK_NUM-1:0][RS_W-1:0]  rs_out;
  logic [BANK_NUM-1:0][OPT_W-1:0] opt_out;

  // Set ready bits of an entry for any source matching a writeback this cycle.
  function automatic rs_base_t wake(input rs_base_t e,
                                    input logic [WB_W-1:0] v,
                                    input logic [WB_W-1:0][PREG_W-1:0] p);
    rs_base_t r;
    r = e;
    for (int k = 0; k < WB_W; k++) begin
      if (v[k]) begin
        if (r.psrc0 == p[k]) r.psrc0_ready = 1'b1;
        if (r.psrc1 == p[k]) r.psrc1_ready = 1'b1;
      end
    end
    return r;
  endfunction

  assign count     = tail - head;
  assign enq_ready = (count <= ENQ_LIMIT);

  // Enqueue: only the contiguous valid prefix from slot 0 is taken.
  always_comb begin
    logic stop;
    stop  = 1'b0;
    enq_n = '0;
    for (int i = 0; i < ENQ_WIDTH; i++) begin
      wr_idx[i] = tail[IDX_W-1:0] + IDX_W'(i);
      if (!stop && dq.enq_valid_i[i]) enq_n = enq_n + 1'b1;
      else                            stop  = 1'b1;
    end
    if (!enq_ready) enq_n = '0;
  end

  // Dispatch: present head..head+BANK_NUM-1, stop at the first refused port.
  always_comb begin
    logic stop;
    stop  = 1'b0;
    deq_k = '0;
    for (int j = 0; j < BANK_NUM; j++) begin
      rd_idx[j]       = head[IDX_W-1:0] + IDX_W'(j);
      wr_valid[j]     = (count > PTR_W'(j)) && !flush_i;
      bypass[j]       = wake(mem[rd_idx[j]], wb_i, wb_pdest_i);
      bypass[j].valid = 1'b1;
      rs_out[j]       = wr_valid[j] ? RS_W'(bypass[j]) : '0;
      opt_out[j]      = wr_valid[j] ? opt_mem[rd_idx[j]] : '0;
      if (!stop && wr_valid[j] && dq.wr_ready_i[j]) deq_k = deq_k + 1'b1;
      else                                          stop  = 1'b1;
    end
  end

  assign dq.enq_ready_o   = enq_ready;
  assign dq.wr_valid_o    = wr_valid;
  assign dq.rs_base_o     = rs_out;
  assign dq.option_code_o = opt_out;

  // Enqueue slots are always free and dispatch slots always occupied, so
  // the per-entry writes below never collide within one edge.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      head <= '0;
      tail <= '0;
      live <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        mem[i]     <= '0;
        opt_mem[i] <= '0;
      end
    end else if (flush_i) begin
      head <= '0;
      tail <= '0;
      live <= '0;
    end else begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        if (live[i]) mem[i] <= wake(mem[i], wb_i, wb_pdest_i);
      end
      for (int j = 0; j < BANK_NUM; j++) begin
        if (PTR_W'(j) < deq_k) live[rd_idx[j]] <= 1'b0;
      end
      for (int i = 0; i < ENQ_WIDTH; i++) begin
        if (PTR_W'(i) < enq_n) begin
          mem[wr_idx[i]]     <= wake(rs_base_t'(dq.rs_base_i[i]), wb_i, wb_pdest_i);
          opt_mem[wr_idx[i]] <= dq.option_code_i[i];
          live[wr_idx[i]]    <= 1'b1;
        end
      end
      head <= head + deq_k;
      tail <= tail + enq_n;
    end
  end

endmodule

`default_nettype wire
